// File: rtl/ram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ram_ctrl_pkg
//  Purpose  : Shared types and default widths for the RAM port controller.
//  Revision : 1.0 - initial release
// ============================================================================
package ram_ctrl_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;

  // Sequencer states; IDLE is the only state in which key presses are taken.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_READ_WAIT = 3'd2,
    ST_READ_CAP  = 3'd3,
    ST_FILL      = 3'd4
  } ram_ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : key_debounce
//  Purpose  : Synchronizes a raw pushbutton, debounces it with a run-length
//             counter and emits a one-cycle pulse on each accepted press.
//  Revision : 1.0 - initial release
// ============================================================================
module key_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic key_raw,
  output logic press
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             level_prev_q, level_prev_d;
  logic             armed_q, armed_d;
  logic             press_q, press_d;

  // Two-flop synchronizer; left unreset so a key held through reset is still
  // seen as held (and therefore not armed) once reset drops.
  always_ff @(posedge clock) begin
    sync1_q <= key_raw;
    sync2_q <= sync1_q;
  end

  // Debounce run counter, edge detect and re-arm after an observed release.
  always_comb begin
    cnt_d        = '0;
    level_d      = level_q;
    level_prev_d = level_q;
    armed_d      = armed_q | ~sync2_q;
    press_d      = level_q & ~level_prev_q & armed_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      armed_q      <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      armed_q      <= armed_d;
      press_q      <= press_d;
    end
  end

  assign press = press_q;

endmodule
`default_nettype wire

// File: rtl/ram_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ram_port_ctrl
//  Purpose  : Turns debounced button presses and switch settings into
//             registered RAM write strobes, read captures and a fill burst.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_port_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DB_CYCLES = 4,
  parameter int RD_LAT    = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              key_wr,
  input  logic              key_rd,
  input  logic              key_fill,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic [DATA_W-1:0] sw_data,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy
);

  localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

  logic wr_press, rd_press, fill_press;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_wr (
    .clock(clock), .reset(reset), .key_raw(key_wr), .press(wr_press)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_rd (
    .clock(clock), .reset(reset), .key_raw(key_rd), .press(rd_press)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_fill (
    .clock(clock), .reset(reset), .key_raw(key_fill), .press(fill_press)
  );

  ram_ctrl_state_t   state_q, state_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;
  logic              ram_wren_q, ram_wren_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] next_addr;

  // Sequencer next state and registered RAM-side outputs.
  always_comb begin
    state_d       = state_q;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    ram_wren_d    = 1'b0;
    wait_d        = wait_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = 1'b0;
    next_addr     = ram_address_q + ADDR_W'(1);
    case (state_q)
      ST_IDLE: begin
        // Fill outranks write, write outranks read.
        if (fill_press) begin
          ram_address_d = '0;
          ram_data_d    = sw_data;
          ram_wren_d    = 1'b1;
          state_d       = ST_FILL;
        end else if (wr_press) begin
          ram_address_d = sw_addr;
          ram_data_d    = sw_data;
          ram_wren_d    = 1'b1;
          state_d       = ST_WRITE;
        end else if (rd_press) begin
          ram_address_d = sw_addr;
          wait_d        = WAIT_W'(RD_LAT);
          state_d       = ST_READ_WAIT;
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      ST_READ_WAIT: begin
        wait_d = wait_q - WAIT_W'(1);
        if (wait_q <= WAIT_W'(1)) begin
          state_d = ST_READ_CAP;
        end
      end
      ST_READ_CAP: begin
        rd_data_d  = ram_q;
        rd_valid_d = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_FILL: begin
        // The last entry is on the bus this cycle; stop without wrapping.
        if (ram_address_q == '1) begin
          state_d = ST_IDLE;
        end else begin
          ram_address_d = next_addr;
          ram_data_d    = sw_data + DATA_W'(next_addr);
          ram_wren_d    = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Sequencer and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
      wait_q        <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wren_q    <= ram_wren_d;
      wait_q        <= wait_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;
  assign ram_wren    = ram_wren_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_port_ctrl
//  Purpose  : Self-checking bench for ram_port_ctrl with a behavioural RAM
//             and an expected-memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_ctrl;

  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int DB    = 4;
  localparam int RL    = 1;
  localparam int DEPTH = 1 << AW;
  localparam int LAT   = 2 + DB + 2;  // raw edge -> first wren-high cycle

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          key_wr = 1'b0, key_rd = 1'b0, key_fill = 1'b0;
  logic [AW-1:0] sw_addr = '0;
  logic [DW-1:0] sw_data = '0;
  logic [DW-1:0] ram_q;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data, rd_data;
  logic          ram_wren, rd_valid, busy;

  int checks = 0;
  int errors = 0;

  ram_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DB_CYCLES(DB), .RD_LAT(RL)) dut (
    .clock(clock), .reset(reset),
    .key_wr(key_wr), .key_rd(key_rd), .key_fill(key_fill),
    .sw_addr(sw_addr), .sw_data(sw_data), .ram_q(ram_q),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
  );

  always #5 clock = ~clock;

  // Behavioural synchronous RAM, one clock of read latency.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  // Expected memory contents, maintained from the operations the bench requests.
  logic [DW-1:0] exp_mem [DEPTH];

  // Observation log of one window of cycles.
  int            ob_wr_n, ob_rd_n, ob_busy_n, ob_first_wr, ob_last_wr, ob_first_rd, ob_first_busy;
  logic [AW-1:0] ob_wa[$];
  logic [DW-1:0] ob_wd[$];
  logic [DW-1:0] ob_rdq[$];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic observe(input int n);
    ob_wa.delete(); ob_wd.delete(); ob_rdq.delete();
    ob_wr_n = 0; ob_rd_n = 0; ob_busy_n = 0;
    ob_first_wr = -1; ob_last_wr = -1; ob_first_rd = -1; ob_first_busy = -1;
    for (int k = 1; k <= n; k++) begin
      @(posedge clock);
      #1;
      if (ram_wren) begin
        ob_wa.push_back(ram_address);
        ob_wd.push_back(ram_data);
        ob_wr_n++;
        if (ob_first_wr < 0) ob_first_wr = k;
        ob_last_wr = k;
      end
      if (rd_valid) begin
        ob_rdq.push_back(rd_data);
        ob_rd_n++;
        if (ob_first_rd < 0) ob_first_rd = k;
      end
      if (busy) begin
        ob_busy_n++;
        if (ob_first_busy < 0) ob_first_busy = k;
      end
    end
  endtask

  // Hold the given keys for n cycles while observing, then release and settle.
  task automatic do_keys(input logic w, input logic r, input logic f, input int n);
    key_wr = w; key_rd = r; key_fill = f;
    observe(n);
    key_wr = 1'b0; key_rd = 1'b0; key_fill = 1'b0;
    tick(DB + 6);
  endtask

  task automatic test_reset();
    reset = 1'b1; key_wr = 1'b0; key_rd = 1'b0; key_fill = 1'b0;
    tick(4);
    checks++;
    if (ram_address !== '0 || ram_data !== '0 || ram_wren !== 1'b0 ||
        rd_data !== '0 || rd_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state addr=%0h data=%0h wren=%0b rd_data=%0h rd_valid=%0b busy=%0b expected all 0",
               ram_address, ram_data, ram_wren, rd_data, rd_valid, busy);
    end
    reset = 1'b0;
    observe(DB + 6);
    checks++;
    if (ob_wr_n !== 0 || ob_busy_n !== 0) begin
      errors++;
      $display("FAIL idle_after_reset writes=%0d busy_cycles=%0d expected 0 0", ob_wr_n, ob_busy_n);
    end
  endtask

  task automatic test_write();
    sw_addr = AW'(5); sw_data = 8'hA7; key_wr = 1'b1;
    for (int k = 1; k <= LAT + 4; k++) begin
      @(posedge clock);
      #1;
      checks++;
      if (ram_wren !== (k == LAT) || busy !== (k == LAT)) begin
        errors++;
        $display("FAIL write_strobe cycle=%0d wren=%0b busy=%0b expected %0b",
                 k, ram_wren, busy, (k == LAT));
      end
      if (k == LAT) begin
        checks++;
        if (ram_address !== AW'(5) || ram_data !== 8'hA7) begin
          errors++;
          $display("FAIL write_payload addr=%0h data=%0h expected 5 a7", ram_address, ram_data);
        end
      end
    end
    exp_mem[5] = 8'hA7;
    key_wr = 1'b0;
    observe(DB + 6);
    checks++;
    if (ob_wr_n !== 0 || ob_busy_n !== 0) begin
      errors++;
      $display("FAIL release_quiet writes=%0d busy_cycles=%0d expected 0 0", ob_wr_n, ob_busy_n);
    end
  endtask

  task automatic test_bounce();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = AW'($urandom); d = DW'($urandom);
    if (a == AW'(5)) a = AW'(6);
    sw_addr = a; sw_data = d;
    fork
      observe(8 + LAT + 6);
      begin
        key_wr = 1'b1; tick(2); key_wr = 1'b0; tick(2);
        key_wr = 1'b1; tick(2); key_wr = 1'b0; tick(2);
        key_wr = 1'b1;
      end
    join
    key_wr = 1'b0;
    tick(DB + 6);
    exp_mem[a] = d;
    checks++;
    if (ob_wr_n !== 1 || ob_first_wr !== 8 + LAT) begin
      errors++;
      $display("FAIL bounce_single_strobe writes=%0d first_cycle=%0d expected 1 %0d",
               ob_wr_n, ob_first_wr, 8 + LAT);
    end else begin
      checks++;
      if (ob_wa[0] !== a || ob_wd[0] !== d) begin
        errors++;
        $display("FAIL bounce_payload addr=%0h data=%0h expected %0h %0h", ob_wa[0], ob_wd[0], a, d);
      end
    end
  endtask

  task automatic test_read();
    sw_addr = AW'(5);
    do_keys(1'b0, 1'b1, 1'b0, LAT + 6);
    checks++;
    if (ob_rd_n !== 1 || ob_wr_n !== 0 || ob_busy_n !== 1 + RL) begin
      errors++;
      $display("FAIL read_pulse rd_valids=%0d writes=%0d busy_cycles=%0d expected 1 0 %0d",
               ob_rd_n, ob_wr_n, ob_busy_n, 1 + RL);
    end else begin
      checks++;
      if (ob_rdq[0] !== exp_mem[5] || ob_first_busy !== LAT || ob_first_rd !== ob_first_busy + 2) begin
        errors++;
        $display("FAIL read_data data=%0h busy_at=%0d valid_at=%0d expected %0h %0d %0d",
                 ob_rdq[0], ob_first_busy, ob_first_rd, exp_mem[5], LAT, LAT + 2);
      end
    end
  endtask

  task automatic test_random_rw();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < 4; i++) begin
      a = AW'($urandom); d = DW'($urandom);
      sw_addr = a; sw_data = d;
      do_keys(1'b1, 1'b0, 1'b0, LAT + 3);
      exp_mem[a] = d;
      checks++;
      if (ob_wr_n !== 1 || (ob_wr_n == 1 && (ob_wa[0] !== a || ob_wd[0] !== d))) begin
        errors++;
        $display("FAIL rand_write iter=%0d writes=%0d expected 1 at %0h=%0h", i, ob_wr_n, a, d);
      end
      sw_data = DW'($urandom);
      do_keys(1'b0, 1'b1, 1'b0, LAT + 4);
      checks++;
      if (ob_rd_n !== 1 || rd_data !== exp_mem[a]) begin
        errors++;
        $display("FAIL rand_read iter=%0d rd_valids=%0d data=%0h expected 1 %0h",
                 i, ob_rd_n, rd_data, exp_mem[a]);
      end
    end
  endtask

  task automatic test_fill();
    int bad;
    sw_data = 8'h10;
    fork
      observe(LAT + DEPTH + 12);
      begin
        key_fill = 1'b1; tick(15); key_wr = 1'b1;
      end
    join
    key_fill = 1'b0; key_wr = 1'b0;
    tick(DB + 6);
    checks++;
    if (ob_wr_n !== DEPTH || ob_first_wr !== LAT || ob_last_wr !== LAT + DEPTH - 1 || ob_busy_n !== DEPTH) begin
      errors++;
      $display("FAIL fill_burst writes=%0d first=%0d last=%0d busy_cycles=%0d expected %0d %0d %0d %0d",
               ob_wr_n, ob_first_wr, ob_last_wr, ob_busy_n, DEPTH, LAT, LAT + DEPTH - 1, DEPTH);
    end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i >= ob_wa.size() || ob_wa[i] !== AW'(i) || ob_wd[i] !== DW'(8'h10 + i)) bad++;
      exp_mem[i] = DW'(8'h10 + i);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL fill_contents bad_entries=%0d expected 0", bad);
    end
    sw_addr = AW'(0);
    do_keys(1'b0, 1'b1, 1'b0, LAT + 4);
    checks++;
    if (ob_rd_n !== 1 || rd_data !== 8'h10) begin
      errors++;
      $display("FAIL fill_read0 rd_valids=%0d data=%0h expected 1 10", ob_rd_n, rd_data);
    end
    sw_addr = AW'(DEPTH - 1);
    do_keys(1'b0, 1'b1, 1'b0, LAT + 4);
    checks++;
    if (ob_rd_n !== 1 || rd_data !== 8'h2F) begin
      errors++;
      $display("FAIL fill_read31 rd_valids=%0d data=%0h expected 1 2f", ob_rd_n, rd_data);
    end
  endtask

  task automatic test_priority();
    logic [AW-1:0] a;
    logic [DW-1:0] d, s;
    a = AW'($urandom); d = DW'($urandom);
    sw_addr = a; sw_data = d;
    do_keys(1'b1, 1'b1, 1'b0, LAT + 6);
    exp_mem[a] = d;
    checks++;
    if (ob_wr_n !== 1 || ob_rd_n !== 0 || (ob_wr_n == 1 && (ob_wa[0] !== a || ob_wd[0] !== d))) begin
      errors++;
      $display("FAIL prio_wr_over_rd writes=%0d rd_valids=%0d expected 1 0", ob_wr_n, ob_rd_n);
    end
    s = DW'($urandom);
    sw_data = s;
    do_keys(1'b1, 1'b0, 1'b1, LAT + DEPTH + 6);
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = DW'(s + i);
    checks++;
    if (ob_wr_n !== DEPTH || ob_first_wr !== LAT ||
        (ob_wr_n == DEPTH && (ob_wa[0] !== '0 || ob_wd[DEPTH-1] !== DW'(s + DEPTH - 1)))) begin
      errors++;
      $display("FAIL prio_fill_over_wr writes=%0d first=%0d expected %0d %0d", ob_wr_n, ob_first_wr, DEPTH, LAT);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [DW-1:0] s;
    logic [AW-1:0] a;
    int n;
    s = DW'($urandom);
    sw_data = s; key_fill = 1'b1;
    n = 0;
    while (!(ram_wren === 1'b1 && ram_address === AW'(12)) && n < LAT + 20) begin
      tick(1);
      n++;
    end
    checks++;
    if (!(ram_wren === 1'b1 && ram_address === AW'(12))) begin
      errors++;
      $display("FAIL reach_addr12 wren=%0b addr=%0h expected 1 c", ram_wren, ram_address);
    end
    reset = 1'b1;
    tick(1);
    checks++;
    if (ram_wren !== 1'b0 || busy !== 1'b0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_fill wren=%0b busy=%0b rd_valid=%0b expected 0 0 0", ram_wren, busy, rd_valid);
    end
    reset = 1'b0;
    observe(40);
    checks++;
    if (ob_wr_n !== 0 || ob_busy_n !== 0) begin
      errors++;
      $display("FAIL held_key_no_reburst writes=%0d busy_cycles=%0d expected 0 0", ob_wr_n, ob_busy_n);
    end
    key_fill = 1'b0;
    tick(DB + 6);
    do_keys(1'b0, 1'b0, 1'b1, LAT + DEPTH + 4);
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = DW'(s + i);
    checks++;
    if (ob_wr_n !== DEPTH || ob_first_wr !== LAT) begin
      errors++;
      $display("FAIL refill_after_release writes=%0d first=%0d expected %0d %0d", ob_wr_n, ob_first_wr, DEPTH, LAT);
    end
    a = AW'($urandom);
    sw_addr = a;
    do_keys(1'b0, 1'b1, 1'b0, LAT + 4);
    checks++;
    if (ob_rd_n !== 1 || rd_data !== exp_mem[a]) begin
      errors++;
      $display("FAIL refill_read addr=%0h rd_valids=%0d data=%0h expected 1 %0h", a, ob_rd_n, rd_data, exp_mem[a]);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_bounce();
    test_read();
    test_random_rw();
    test_fill();
    test_priority();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/ram_port_ctrl.md
Name: ram_port_ctrl

Overview:
Upstream control stage for the 32x8 LPM RAM on the DE2 lab board. It turns raw pushbutton presses plus switch-selected address/data into clean, single-cycle RAM write strobes, read-capture sequences and a whole-memory fill burst. Its outputs drive the RAM address, data and wren pins directly. It also registers the RAM q output for the hex display path.

Parameters:
ADDR_W, 5, RAM address width (depth = 2^ADDR_W)
DATA_W, 8, RAM data width
DB_CYCLES, 4, consecutive equal samples needed to accept a new button level (board build: 500000 at 50 MHz)
RD_LAT, 1, clocks from address presented to ram_q valid

Ports:
clock  in  1  system clock; also drives the RAM clock
reset  in  1  synchronous, active-high reset
key_wr  in  1  raw write button, active-high when pressed (asynchronous)
key_rd  in  1  raw read button, active-high (asynchronous)
key_fill  in  1  raw fill button, active-high (asynchronous)
sw_addr  in  ADDR_W  switch address
sw_data  in  DATA_W  switch data / fill seed
ram_q  in  DATA_W  RAM read data
ram_address  out  ADDR_W  registered RAM address
ram_data  out  DATA_W  registered RAM write data
ram_wren  out  1  registered RAM write enable
rd_data  out  DATA_W  last captured read value
rd_valid  out  1  one-cycle pulse when rd_data updates
busy  out  1  high in any state other than IDLE

Behaviour:
- One clock (clock); reset is synchronous, active-high. All logic is on the rising edge.
- Reset values: ram_address=0, ram_data=0, ram_wren=0, rd_data=0, rd_valid=0, busy=0, FSM=IDLE, debounced levels=0, all counters=0.
- Each key passes through a 2-flop synchronizer and then a debounce counter.
  - The debounced level changes only after DB_CYCLES consecutive samples differ from the current level.
  - The counter restarts on any bounce.
  - A rising edge of the debounced level produces a one-cycle press pulse.
  - Latency from a stable raw edge to the press pulse is 2+DB_CYCLES+1 clocks.
- Press pulses are accepted only in IDLE; pulses arriving while busy are dropped, not queued.
- Same-cycle pulse priority: fill > write > read.
- FSM states: IDLE, WRITE, READ_WAIT, READ_CAP, FILL.
  - IDLE: ram_wren=0. ram_address and ram_data hold their last values.
    - On a fill pulse: ram_address<=0, ram_data<=sw_data, ram_wren<=1, go to FILL.
    - On a write pulse: ram_address<=sw_addr, ram_data<=sw_data, ram_wren<=1, go to WRITE.
    - On a read pulse: ram_address<=sw_addr, ram_wren<=0, load wait counter with RD_LAT, go to READ_WAIT.
  - WRITE: the wren-high cycle. ram_wren<=0, go to IDLE. ram_wren is high for exactly one clock.
  - READ_WAIT: decrement the counter each clock. Go to READ_CAP when the counter reaches 1.
  - READ_CAP: rd_data<=ram_q, rd_valid<=1 for one clock, go to IDLE.
  - FILL: ram_wren stays high. Each clock, ram_address increments and ram_data<=sw_data+next_address, truncated mod 2^DATA_W. This writes sw_data+addr at every address, using sw_data sampled each cycle; switches are held static by convention.
    - When ram_address=2^ADDR_W-1 is being written, ram_wren<=0 and the FSM returns to IDLE.
    - The burst is exactly 2^ADDR_W write cycles, with no address wrap beyond the last entry.
- busy is registered and high exactly while the FSM is not in IDLE.
- Reset during any state (including mid-FILL or READ_WAIT):
  - return to IDLE and deassert ram_wren and rd_valid at that edge;
  - leave no partial pending operation;
  - clear the debounce levels, so a button still held is not re-detected until it is released and pressed again.
- Holding a button produces exactly one press; release produces nothing.

Decomposition:
- Shared package ram_ctrl_pkg holds:
  - the FSM state enum ram_ctrl_state_t;
  - the default widths ADDR_W=5 and DATA_W=8.
- Sub-module key_debounce (parameter DB_CYCLES): 2-flop synchronizer, counter, debounced level and press pulse. It is instantiated three times.

Test Plan:
- Reset, then press key_wr with sw_addr=5, sw_data=8'hA7 -> exactly one cycle with ram_wren=1, ram_address=5, ram_data=A7, starting 2+DB_CYCLES+2 clocks after the raw edge; busy high for 1 cycle.
- key_wr bouncing 1-0-1-0 with pulse width < DB_CYCLES, then held stable -> exactly one write strobe, none during the bounce.
- After the write above, press key_rd with sw_addr=5, using a behavioural RAM model with RD_LAT=1 -> rd_valid pulses once with rd_data=A7, 2 clocks after leaving IDLE.
- key_fill with sw_data=8'h10 -> 32 consecutive wren cycles at addresses 0..31 with data 10..2F; busy high 32 clocks; a key_wr press mid-burst is ignored; reads of addresses 0 and 31 afterwards return 10 and 2F.
- key_wr and key_rd pulses arriving in the same cycle -> only the write executes, no rd_valid; key_fill plus key_wr in the same cycle -> fill executes.
- Assert reset at burst address 12 -> ram_wren=0 and busy=0 on the next edge; key_fill still held produces no new burst until it is released and pressed again.
